// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
//   Shared types and constants for the SPI-attached 256x8 RAM target.
//   - state_e      : framing FSM states of spi_ram_slave
//   - CMD_*        : 2-bit command codes carried in rx_data[9:8]
//   - DEFAULT_*    : default memory geometry
//   - RX_BITS / RX_LAST : length of the command/data word shifted per frame
//   - TX_BITS      : number of MISO clocks per read-data frame
// -----------------------------------------------------------------------------
package spi_ram_pkg;

    localparam int DEFAULT_MEM_DEPTH = 256;
    localparam int DEFAULT_ADDR_SIZE = 8;

    // A frame carries 10 bits after the select bit: 2 command bits + 8 payload.
    localparam logic [3:0] RX_BITS = 4'd10;
    localparam logic [3:0] RX_LAST = 4'd9;

    // Read data is serialized as one byte, MSB first.
    localparam logic [3:0] TX_BITS = 4'd8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

endpackage

// File: rtl/spi_ram.sv
// -----------------------------------------------------------------------------
// spi_ram
//   Single-port RAM with a 10-bit command/data interface. Each rx_valid pulse
//   delivers one word: din[9:8] selects the command, din[7:0] the payload.
//     00 : latch write address
//     01 : write payload to mem[write address]
//     10 : latch read address
//     11 : load mem[read address] into dout, pulse tx_valid for one cycle
//   Addresses never auto-increment. Memory contents are not reset.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset (address regs, dout, tx_valid)
//   din      in   [9:0] command/data word
//   rx_valid in   one-cycle strobe qualifying din
//   dout     out  [7:0] read data
//   tx_valid out  one-cycle strobe, dout freshly loaded
// -----------------------------------------------------------------------------
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] payload_addr;
    logic                 mem_we;

    assign cmd          = din[9:8];
    assign payload_addr = din[ADDR_SIZE-1:0];
    // Reset wins over a coincident write strobe.
    assign mem_we       = !rst && rx_valid && (cmd == CMD_WR_DATA);

    // Address/output registers (reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= payload_addr;
                    CMD_WR_DATA: ;
                    CMD_RD_ADDR: rd_addr <= payload_addr;
                    CMD_RD_DATA: begin
                        dout     <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage array: deliberately has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= din[7:0];
        end
    end

endmodule

// File: rtl/spi_ram_slave.sv
// -----------------------------------------------------------------------------
// spi_ram_slave
//   SPI mode-0 slave (MSB first, sampled on the system clock) fronting a
//   256x8 RAM. A frame is: SS_n low, one select bit, then 10 bits shifted into
//   rx_data. When the 10th bit arrives rx_valid pulses and the RAM decodes
//   rx_data[9:8]. A read-data word makes the RAM pulse tx_valid; the byte is
//   then returned on MISO MSB first, one bit per clock, while SS_n stays low.
//
//   The select bit only steers the FSM; the RAM acts on rx_data[9:8] alone.
//   rd_addr_flag alternates the select=1 path between READ_ADD and READ_DATA:
//   set when a READ_ADD frame completes, cleared when a READ_DATA frame does.
//
//   Handshake: rx_valid and tx_valid are single-cycle strobes with no ready;
//   the consumer must act on the cycle they are high.
//
//   SS_n high forces IDLE on the next edge, clears the bit counter and shift
//   register and drives MISO to 0. An aborted frame never raises rx_valid.
//   Bits after the 10th in a frame are ignored until SS_n returns high.
//
// Ports
//   clk   in   system clock; MOSI/SS_n sampled and MISO updated on rising edge
//   rst   in   synchronous active-high reset, priority over SS_n
//   MOSI  in   serial data in
//   SS_n  in   active-low slave select
//   MISO  out  serial read data; 0 whenever not shifting a byte out
// -----------------------------------------------------------------------------
module spi_ram_slave
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic clk,
    input  logic rst,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO
);

    state_e     state;
    state_e     next_state;

    logic [3:0] bit_cnt;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       rd_addr_flag;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic [7:0] tx_shift;
    logic [3:0] tx_cnt;

    logic       in_frame_body;
    logic       shift_en;
    logic       last_bit;

    assign in_frame_body = (state == WRITE) || (state == READ_ADD) ||
                           (state == READ_DATA);
    // Stop shifting once 10 bits are in; extra bits are dropped.
    assign shift_en      = in_frame_body && !SS_n && (bit_cnt != RX_BITS);
    assign last_bit      = shift_en && (bit_cnt == RX_LAST);

    // ---------------------------------------------------------------------
    // Framing FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!SS_n) next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)               next_state = IDLE;
                else if (!MOSI)         next_state = WRITE;
                else if (!rd_addr_flag) next_state = READ_ADD;
                else                    next_state = READ_DATA;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Receive shifter, bit counter, rx_valid strobe, read-path flag
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_flag <= 1'b0;
        end else begin
            rx_valid <= last_bit;

            if (SS_n || (state == IDLE)) begin
                bit_cnt <= '0;
                rx_data <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 4'd1;
                rx_data <= {rx_data[8:0], MOSI};
            end

            // Only completed frames move the flag; aborts leave it alone.
            if (last_bit && (state == READ_ADD)) begin
                rd_addr_flag <= 1'b1;
            end else if (last_bit && (state == READ_DATA)) begin
                rd_addr_flag <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Transmit serializer. The byte is captured on the tx_valid cycle and
    // MISO starts with bit 7 on the following edge, so MISO is purely
    // registered and the first data bit lags tx_valid by one clock.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || SS_n) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
            MISO     <= 1'b0;
        end else if (tx_valid) begin
            tx_shift <= tx_data;
            tx_cnt   <= TX_BITS;
            MISO     <= 1'b0;
        end else if (tx_cnt != 4'd0) begin
            MISO     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
            tx_cnt   <= tx_cnt - 4'd1;
        end else begin
            MISO     <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Memory
    // ---------------------------------------------------------------------
    spi_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .din      (rx_data),
        .rx_valid (rx_valid),
        .dout     (tx_data),
        .tx_valid (tx_valid)
    );

endmodule

// File: tb/tb_spi_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_slave
//   Drives SPI frames into spi_ram_slave and checks MISO, strobes and FSM path
//   against a frame-level memory model (array + address registers + a read
//   path toggle), plus a table of directed frames with constant expectations.
// -----------------------------------------------------------------------------
module tb_spi_ram_slave;
    import spi_ram_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic MOSI = 1'b0;
    logic SS_n = 1'b1;
    logic MISO;

    always #5 clk = ~clk;

    spi_ram_slave #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .MOSI (MOSI),
        .SS_n (SS_n),
        .MISO (MISO)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Scoreboard counters and check helper
    // ------------------------------------------------------------------
    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------
    logic [7:0] m_mem   [256];
    bit         m_known [256];
    logic [7:0] m_wr;
    logic [7:0] m_rd;
    bit         m_flag;        // 1: next select=1 frame is a read-data frame
    logic [7:0] exp_q [$];     // bytes expected on MISO

    task automatic model_reset();
        m_wr   = 8'h00;
        m_rd   = 8'h00;
        m_flag = 1'b0;
    endtask

    // Returns 1 when the frame carries a read-data command (queues expected).
    function automatic bit model_frame(input logic sel, input logic [9:0] pl);
        bit is_rd;
        is_rd = 1'b0;
        case (pl[9:8])
            2'b00: m_wr = pl[7:0];
            2'b01: begin m_mem[m_wr] = pl[7:0]; m_known[m_wr] = 1'b1; end
            2'b10: m_rd = pl[7:0];
            default: begin
                is_rd = 1'b1;
                if (m_known[m_rd]) exp_q.push_back(m_mem[m_rd]);
            end
        endcase
        if (sel) m_flag = !m_flag;
        return is_rd;
    endfunction

    // ------------------------------------------------------------------
    // Driver: one complete frame. Starts and ends at a negedge with SS_n=1.
    // Inputs change on negedges; outputs are sampled on negedges.
    // ------------------------------------------------------------------
    task automatic do_frame(input logic sel, input logic [9:0] pl,
                            input bit chk_miso, output logic [7:0] got);
        state_e     exp_st;
        logic [10:0] bits;
        bit          is_rd;
        bit          have_exp;
        logic [7:0]  exp_b;
        exp_st = !sel ? WRITE : (m_flag ? READ_DATA : READ_ADD);
        bits   = {sel, pl};
        got    = 8'h00;

        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            if (i == 10) check("state_chk_cmd", dut.state, CHK_CMD);
            if (i == 9)  check("state_path", dut.state, exp_st);
            MOSI = bits[i];
        end
        @(negedge clk);                       // after edge 11
        check("rx_valid_pulse", dut.rx_valid, 1'b1);
        MOSI = 1'b0;

        have_exp = 1'b0;
        exp_b    = 8'h00;
        is_rd    = model_frame(sel, pl);
        if (is_rd && exp_q.size() > 0) begin
            exp_b    = exp_q.pop_front();
            have_exp = 1'b1;
        end

        if (is_rd) begin
            @(negedge clk);                   // after edge 12
            check("tx_valid_pulse", dut.tx_valid, 1'b1);
            @(negedge clk);                   // after edge 13
            check("miso_lead", MISO, 1'b0);
            for (int k = 7; k >= 0; k--) begin
                @(negedge clk);               // after edges 14..21
                got[k] = MISO;
            end
            @(negedge clk);                   // after edge 22
            check("miso_tail", MISO, 1'b0);
            if (chk_miso && have_exp) check("miso_byte_model", got, exp_b);
        end
        SS_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Directed table
    // ------------------------------------------------------------------
    typedef struct {
        logic       sel;
        logic [9:0] pl;
        bit         chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    logic [7:0] got;
    logic [7:0] ra [10];
    logic [7:0] rd [10];

    initial begin
        // Table: read of 0x3C after the sweep, repeated read-data frame that
        // takes the READ_ADD path, re-alignment frame, then overwrite 0x3C.
        vecs[0] = '{1'b1, {2'b10, 8'h3C}, 1'b1, 8'h00};
        vecs[1] = '{1'b1, {2'b11, 8'h00}, 1'b1, 8'h99};
        vecs[2] = '{1'b1, {2'b11, 8'h00}, 1'b0, 8'h00};
        vecs[3] = '{1'b1, {2'b11, 8'h00}, 1'b1, 8'h99};
        vecs[4] = '{1'b0, {2'b00, 8'h3C}, 1'b0, 8'h00};
        vecs[5] = '{1'b0, {2'b01, 8'h42}, 1'b0, 8'h00};
        vecs[6] = '{1'b1, {2'b10, 8'h3C}, 1'b0, 8'h00};
        vecs[7] = '{1'b1, {2'b11, 8'h00}, 1'b1, 8'h42};
        vecs[0].chk = 1'b0;

        for (int i = 0; i < 256; i++) begin
            m_mem[i]   = 8'h00;
            m_known[i] = 1'b0;
        end

        // Reset values.
        @(negedge clk);
        apply_reset();
        check("rst_miso", MISO, 1'b0);
        check("rst_state", dut.state, IDLE);
        check("rst_rx_valid", dut.rx_valid, 1'b0);
        check("rst_tx_valid", dut.tx_valid, 1'b0);
        check("rst_flag", dut.rd_addr_flag, 1'b0);
        check("rst_wr_addr", dut.u_ram.wr_addr, 8'h00);
        check("rst_rd_addr", dut.u_ram.rd_addr, 8'h00);
        check("rst_tx_data", dut.u_ram.dout, 8'h00);

        // Idle with SS_n high.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_miso", MISO, 1'b0);
            check("idle_rx_valid", dut.rx_valid, 1'b0);
        end

        // Fill every address with a ^ 8'hA5.
        for (int a = 0; a < 256; a++) begin
            do_frame(1'b0, {2'b00, 8'(a)}, 1'b1, got);
            do_frame(1'b0, {2'b01, 8'(a) ^ 8'hA5}, 1'b1, got);
        end

        // Read every address back.
        for (int a = 0; a < 256; a++) begin
            do_frame(1'b1, {2'b10, 8'(a)}, 1'b1, got);
            do_frame(1'b1, {2'b11, 8'($urandom_range(0, 255))}, 1'b1, got);
            check("sweep_byte", got, 8'(a) ^ 8'hA5);
        end

        // Directed table.
        for (int v = 0; v < 8; v++) begin
            do_frame(vecs[v].sel, vecs[v].pl, vecs[v].chk, got);
            if (vecs[v].chk) check("table_byte", got, vecs[v].exp);
        end
        check("table_flag", dut.rd_addr_flag, 1'b0);

        // Aborted write-data frame: set address 0x20, then 5 bits and SS_n up.
        do_frame(1'b0, {2'b00, 8'h20}, 1'b1, got);
        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge clk); MOSI = 1'b0;          // select
        @(negedge clk); MOSI = 1'b0;          // rx_data[9]
        @(negedge clk); MOSI = 1'b1;          // rx_data[8]
        @(negedge clk); MOSI = 1'b1;          // D7
        @(negedge clk); MOSI = 1'b1;          // D6
        @(negedge clk); MOSI = 1'b1;          // D5
        @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_rx_valid", dut.rx_valid, 1'b0);
        end
        check("abort_state", dut.state, IDLE);
        do_frame(1'b1, {2'b10, 8'h20}, 1'b1, got);
        do_frame(1'b1, {2'b11, 8'h00}, 1'b1, got);
        check("abort_mem_kept", got, 8'h85);

        // Random overwrites, then read back.
        for (int n = 0; n < 10; n++) begin
            ra[n] = 8'($urandom_range(0, 255));
            rd[n] = 8'($urandom_range(0, 255));
            do_frame(1'b0, {2'b00, ra[n]}, 1'b1, got);
            do_frame(1'b0, {2'b01, rd[n]}, 1'b1, got);
        end
        for (int n = 0; n < 10; n++) begin
            do_frame(1'b1, {2'b10, ra[n]}, 1'b1, got);
            do_frame(1'b1, {2'b11, 8'h00}, 1'b1, got);
        end

        // Reset in the middle of a read-data frame.
        do_frame(1'b1, {2'b10, 8'h77}, 1'b1, got);
        begin
            logic [10:0] bits;
            logic [7:0]  exp_b;
            exp_b = m_mem[8'h77];
            bits  = {1'b1, 2'b11, 8'h00};
            SS_n  = 1'b0;
            MOSI  = 1'b0;
            for (int i = 10; i >= 0; i--) begin
                @(negedge clk);
                MOSI = bits[i];
            end
            @(negedge clk);                   // after edge 11
            MOSI = 1'b0;
            repeat (3) @(negedge clk);        // after edge 14
            check("midrd_first_bit", MISO, exp_b[7]);
            repeat (2) @(negedge clk);        // after edge 16
            rst = 1'b1;
            @(negedge clk);
            check("midrd_rst_miso", MISO, 1'b0);
            check("midrd_rst_state", dut.state, IDLE);
            check("midrd_rst_flag", dut.rd_addr_flag, 1'b0);
            SS_n = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            @(negedge clk);
            check("post_rst_miso", MISO, 1'b0);
        end
        // RAM contents survive reset; flag restarts at READ_ADD.
        do_frame(1'b1, {2'b10, 8'h77}, 1'b1, got);
        do_frame(1'b1, {2'b11, 8'h00}, 1'b1, got);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
